// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: counters, blanking, sync, frame strobe and field flag.
// Optional feature macro: VTIMER_SHIFT_EN enables per-field latched hshift/vshift sync shifting.
module video_timing_gen #(
  parameter int HW        = 9,
  parameter int VW        = 9,
  parameter int H_TOTAL   = 432,
  parameter int HB_START  = 320,
  parameter int HB_END    = 0,
  parameter int HS_START  = 360,
  parameter int HS_END    = 380,
  parameter int V_TOTAL   = 262,
  parameter int VB_START  = 240,
  parameter int VB_END    = 0,
  parameter int VS_START  = 244,
  parameter int VS_END    = 247,
  parameter int INTERLACE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pxl_cen,
  input  logic [3:0]    hshift,
  input  logic [3:0]    vshift,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic [VW-1:0] vrender,
  output logic          lhbl,
  output logic          lvbl,
  output logic          hs,
  output logic          vs,
  output logic          display_on,
  output logic          frame_start,
  output logic          field
);

  localparam logic IL = (INTERLACE != 0);

  logic [HW-1:0] r_hpos;
  logic [VW-1:0] r_vpos;
  logic [VW-1:0] r_vrender;
  logic          r_lhbl;
  logic          r_lvbl;
  logic          r_hs;
  logic          r_vs;
  logic          r_display_on;
  logic          r_frame_start;
  logic          r_field;

  logic [HW-1:0] w_hpos_next;
  logic [VW-1:0] w_vpos_next;
  logic [VW-1:0] w_vrender_next;
  logic [VW-1:0] w_last_cur;
  logic [VW-1:0] w_last_next;
  logic          w_hwrap;
  logic          w_vwrap;
  logic          w_field_next;
  logic [HW-1:0] w_hs_on;
  logic [HW-1:0] w_hs_off;
  logic [VW-1:0] w_vs_on;
  logic [VW-1:0] w_vs_off;
  logic          w_lhbl_next;
  logic          w_lvbl_next;
  logic          w_hs_next;
  logic          w_vs_next;

  // Odd interlaced fields carry one extra line.
  assign w_last_cur     = (IL && r_field) ? VW'(V_TOTAL) : VW'(V_TOTAL - 1);
  assign w_hwrap        = (r_hpos == HW'(H_TOTAL - 1));
  assign w_vwrap        = w_hwrap && (r_vpos == w_last_cur);
  assign w_hpos_next    = w_hwrap ? '0 : r_hpos + HW'(1);
  assign w_vpos_next    = w_vwrap ? '0 : (w_hwrap ? r_vpos + VW'(1) : r_vpos);
  assign w_field_next   = (IL && w_vwrap) ? ~r_field : r_field;
  assign w_last_next    = (IL && w_field_next) ? VW'(V_TOTAL) : VW'(V_TOTAL - 1);
  assign w_vrender_next = (w_vpos_next == w_last_next) ? '0 : w_vpos_next + VW'(1);

`ifdef VTIMER_SHIFT_EN
  logic [3:0] r_hs_lat;
  logic [3:0] r_vs_lat;
  logic [3:0] w_hs_lat;
  logic [3:0] w_vs_lat;

  function automatic int wrap_add(input int base, input int delta, input int total);
    int v;
    v = base + delta + total;
    if (v >= total) v = v - total;
    if (v >= total) v = v - total;
    return v;
  endfunction

  // New shifts apply from the first pixel of the next field, never mid-field.
  assign w_hs_lat = w_vwrap ? hshift : r_hs_lat;
  assign w_vs_lat = w_vwrap ? vshift : r_vs_lat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs_lat <= '0;
      r_vs_lat <= '0;
    end else if (pxl_cen) begin
      r_hs_lat <= w_hs_lat;
      r_vs_lat <= w_vs_lat;
    end
  end

  assign w_hs_on  = HW'(wrap_add(HS_START, int'($signed(w_hs_lat)), H_TOTAL));
  assign w_hs_off = HW'(wrap_add(HS_END,   int'($signed(w_hs_lat)), H_TOTAL));
  assign w_vs_on  = VW'(wrap_add(VS_START, int'($signed(w_vs_lat)), int'(w_last_next) + 1));
  assign w_vs_off = VW'(wrap_add(VS_END,   int'($signed(w_vs_lat)), int'(w_last_next) + 1));
`else
  logic w_unused_shift;
  assign w_unused_shift = ^{hshift, vshift};
  assign w_hs_on  = HW'(HS_START);
  assign w_hs_off = HW'(HS_END);
  assign w_vs_on  = VW'(VS_START);
  assign w_vs_off = VW'(VS_END);
`endif

  // Flags are evaluated against the next counter values so they align with hpos/vpos.
  always_comb begin
    w_lhbl_next = r_lhbl;
    w_lvbl_next = r_lvbl;
    w_hs_next   = r_hs;
    w_vs_next   = r_vs;
    if (HB_START != HB_END) begin
      if (w_hpos_next == HW'(HB_START))    w_lhbl_next = 1'b0;
      else if (w_hpos_next == HW'(HB_END)) w_lhbl_next = 1'b1;
    end
    if ((VB_START != VB_END) && (w_hpos_next == HW'(HB_START))) begin
      if (w_vpos_next == VW'(VB_START))    w_lvbl_next = 1'b0;
      else if (w_vpos_next == VW'(VB_END)) w_lvbl_next = 1'b1;
    end
    if (w_hs_on != w_hs_off) begin
      if (w_hpos_next == w_hs_on)       w_hs_next = 1'b1;
      else if (w_hpos_next == w_hs_off) w_hs_next = 1'b0;
    end
    if ((w_vs_on != w_vs_off) && (w_hpos_next == w_hs_on)) begin
      if (w_vpos_next == w_vs_on)       w_vs_next = 1'b1;
      else if (w_vpos_next == w_vs_off) w_vs_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_vrender     <= VW'(1);
      r_lhbl        <= 1'b1;
      r_lvbl        <= 1'b1;
      r_hs          <= 1'b0;
      r_vs          <= 1'b0;
      r_display_on  <= 1'b1;
      r_frame_start <= 1'b0;
      r_field       <= 1'b0;
    end else begin
      r_frame_start <= pxl_cen && w_vwrap;
      if (pxl_cen) begin
        r_hpos       <= w_hpos_next;
        r_vpos       <= w_vpos_next;
        r_vrender    <= w_vrender_next;
        r_lhbl       <= w_lhbl_next;
        r_lvbl       <= w_lvbl_next;
        r_hs         <= w_hs_next;
        r_vs         <= w_vs_next;
        r_display_on <= w_lhbl_next & w_lvbl_next;
        r_field      <= w_field_next;
      end
    end
  end

  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign vrender     = r_vrender;
  assign lhbl        = r_lhbl;
  assign lvbl        = r_lvbl;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign display_on  = r_display_on;
  assign frame_start = r_frame_start;
  assign field       = r_field;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two scaled geometries (progressive, and interlaced with straddling
// blank / wrapping sync) checked every cycle against a region-based raster model.
module tb_video_timing_gen;

`ifdef VTIMER_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  // Instance 0: progressive. Instance 1: interlaced, blank straddles the line wrap.
  localparam int HT  [2] = '{48, 48};
  localparam int HBS [2] = '{36, 40};
  localparam int HBE [2] = '{0, 4};
  localparam int HSS [2] = '{20, 38};
  localparam int HSE [2] = '{26, 46};
  localparam int VT  [2] = '{20, 15};
  localparam int VBS [2] = '{16, 12};
  localparam int VBE [2] = '{0, 1};
  localparam int VSS [2] = '{9, 2};
  localparam int VSE [2] = '{11, 4};
  localparam int ILC [2] = '{0, 1};

  logic clk = 1'b0;
  logic rst;
  logic pxl_cen;
  logic [3:0] hshift;
  logic [3:0] vshift;

  logic [1:0][8:0] hpos_w;
  logic [1:0][8:0] vpos_w;
  logic [1:0][8:0] vr_w;
  logic [1:0] lhbl_w, lvbl_w, hs_w, vs_w, don_w, fs_w, fld_w;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    video_timing_gen #(
      .HW(9), .VW(9),
      .H_TOTAL(HT[gi]), .HB_START(HBS[gi]), .HB_END(HBE[gi]),
      .HS_START(HSS[gi]), .HS_END(HSE[gi]),
      .V_TOTAL(VT[gi]), .VB_START(VBS[gi]), .VB_END(VBE[gi]),
      .VS_START(VSS[gi]), .VS_END(VSE[gi]), .INTERLACE(ILC[gi])
    ) u_dut (
      .clk(clk), .reset(rst), .pxl_cen(pxl_cen), .hshift(hshift), .vshift(vshift),
      .hpos(hpos_w[gi]), .vpos(vpos_w[gi]), .vrender(vr_w[gi]),
      .lhbl(lhbl_w[gi]), .lvbl(lvbl_w[gi]), .hs(hs_w[gi]), .vs(vs_w[gi]),
      .display_on(don_w[gi]), .frame_start(fs_w[gi]), .field(fld_w[gi])
    );
  end

  int n_vec = 0;
  int n_mis = 0;

  // Model state: raster position plus the shifts in force for this and the previous field.
  int m_h[2], m_v[2], m_field[2], m_hlat[2], m_vlat[2], m_phlat[2], m_pvlat[2], m_plen[2];
  bit m_fl[2], m_ff[2], m_fs[2];

  logic nx_rst, nx_cen;
  logic [3:0] nx_h, nx_v;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s[%0d] t=%0t got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  function automatic int md(input int a, input int n);
    int r;
    r = a % n;
    if (r < 0) r = r + n;
    return r;
  endfunction

  function automatic int flen(input int k, input int f);
    return VT[k] + (((ILC[k] != 0) && (f != 0)) ? 1 : 0);
  endfunction

  function automatic bit in_reg(input int p, input int s, input int e);
    if (s < e) return (p >= s) && (p < e);
    return (p >= s) || (p < e);
  endfunction

  // A flag is active over [s,e); before either event in the span it keeps the value it ended with.
  function automatic bit flag_at(input int p, input int s, input int e, input bit prev);
    if (s == e) return 1'b0;
    if ((p < s) && (p < e)) return prev;
    return in_reg(p, s, e);
  endfunction

  task automatic model_reset(input int k);
    m_h[k] = 0; m_v[k] = 0; m_field[k] = 0;
    m_hlat[k] = 0; m_vlat[k] = 0; m_phlat[k] = 0; m_pvlat[k] = 0;
    m_plen[k] = VT[k]; m_fl[k] = 1'b1; m_ff[k] = 1'b1; m_fs[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    if (rst) begin
      model_reset(k);
      return;
    end
    m_fs[k] = 1'b0;
    if (pxl_cen) begin
      m_h[k]++;
      if (m_h[k] == HT[k]) begin
        m_h[k] = 0;
        m_fl[k] = 1'b0;
        m_v[k]++;
        if (m_v[k] == flen(k, m_field[k])) begin
          m_plen[k] = flen(k, m_field[k]);
          m_phlat[k] = m_hlat[k];
          m_pvlat[k] = m_vlat[k];
          m_v[k] = 0;
          m_ff[k] = 1'b0;
          if (ILC[k] != 0) m_field[k] = 1 - m_field[k];
          if (SHIFT_EN) begin
            m_hlat[k] = int'($signed(hshift));
            m_vlat[k] = int'($signed(vshift));
          end
          m_fs[k] = 1'b1;
          $display("frame inst %0d field %0d hlat %0d vlat %0d t=%0t",
                   k, m_field[k], m_hlat[k], m_vlat[k], $time);
        end
      end
    end
  endtask

  task automatic compare_inst(input int k);
    int h, v, len, hh, idx, s, e, ps, pe, pl, plh;
    bit prev, e_hb, e_vb, e_hs, e_vs;
    h = m_h[k]; v = m_v[k]; hh = HT[k]; len = flen(k, m_field[k]); idx = v * hh + h;
    pl = m_plen[k];
    prev = m_fl[k] ? 1'b0 : flag_at(hh - 1, HBS[k], HBE[k], 1'b0);
    e_hb = flag_at(h, HBS[k], HBE[k], prev);
    s = md(HSS[k] + m_hlat[k], hh);
    e = md(HSE[k] + m_hlat[k], hh);
    plh = (v == 0) ? m_phlat[k] : m_hlat[k];
    ps = md(HSS[k] + plh, hh);
    pe = md(HSE[k] + plh, hh);
    prev = m_fl[k] ? 1'b0 : flag_at(hh - 1, ps, pe, 1'b0);
    e_hs = flag_at(h, s, e, prev);
    s = VBS[k] * hh + HBS[k];
    e = VBE[k] * hh + HBS[k];
    prev = m_ff[k] ? 1'b0 : flag_at(pl * hh - 1, s, e, 1'b0);
    e_vb = flag_at(idx, s, e, prev);
    s = md(VSS[k] + m_vlat[k], len) * hh + md(HSS[k] + m_hlat[k], hh);
    e = md(VSE[k] + m_vlat[k], len) * hh + md(HSS[k] + m_hlat[k], hh);
    ps = md(VSS[k] + m_pvlat[k], pl) * hh + md(HSS[k] + m_phlat[k], hh);
    pe = md(VSE[k] + m_pvlat[k], pl) * hh + md(HSS[k] + m_phlat[k], hh);
    prev = m_ff[k] ? 1'b0 : flag_at(pl * hh - 1, ps, pe, 1'b0);
    e_vs = flag_at(idx, s, e, prev);

    chk("hpos", k, int'(hpos_w[k]), h);
    chk("vpos", k, int'(vpos_w[k]), v);
    chk("vrender", k, int'(vr_w[k]), (v == len - 1) ? 0 : v + 1);
    chk("lhbl", k, int'(lhbl_w[k]), int'(!e_hb));
    chk("lvbl", k, int'(lvbl_w[k]), int'(!e_vb));
    chk("hs", k, int'(hs_w[k]), int'(e_hs));
    chk("vs", k, int'(vs_w[k]), int'(e_vs));
    chk("display_on", k, int'(don_w[k]), int'(!e_hb && !e_vb));
    chk("frame_start", k, int'(fs_w[k]), int'(m_fs[k]));
    chk("field", k, int'(fld_w[k]), m_field[k]);
  endtask

  // Hand-computed points that pin the model's geometry.
  task automatic literal_checks();
    if (m_v[0] == 3 && m_h[0] == 35) chk("A_lhbl_35", 0, int'(lhbl_w[0]), 1);
    if (m_v[0] == 3 && m_h[0] == 36) chk("A_lhbl_36", 0, int'(lhbl_w[0]), 0);
    if (m_v[0] == 3 && m_h[0] == 47) chk("A_lhbl_47", 0, int'(lhbl_w[0]), 0);
    if (m_v[0] == 4 && m_h[0] == 0)  chk("A_lhbl_0", 0, int'(lhbl_w[0]), 1);
    if (m_v[0] == 16 && m_h[0] == 35) chk("A_lvbl_pre", 0, int'(lvbl_w[0]), 1);
    if (m_v[0] == 16 && m_h[0] == 36) chk("A_lvbl_fall", 0, int'(lvbl_w[0]), 0);
    if (!m_ff[0] && m_v[0] == 0 && m_h[0] == 10) chk("A_lvbl_carry", 0, int'(lvbl_w[0]), 0);
    if (m_v[0] == 19) chk("A_vrender_last", 0, int'(vr_w[0]), 0);
    if (m_hlat[0] == 0 && m_v[0] == 5 && m_h[0] == 20) chk("A_hs_on", 0, int'(hs_w[0]), 1);
    if (m_hlat[0] == 0 && m_v[0] == 5 && m_h[0] == 26) chk("A_hs_off", 0, int'(hs_w[0]), 0);
    if (m_v[1] == 5 && m_h[1] == 2)  chk("B_lhbl_strad", 1, int'(lhbl_w[1]), 0);
    if (m_v[1] == 5 && m_h[1] == 4)  chk("B_lhbl_rise", 1, int'(lhbl_w[1]), 1);
    if (m_v[1] == 5 && m_h[1] == 39) chk("B_lhbl_39", 1, int'(lhbl_w[1]), 1);
    if (m_field[1] == 0 && m_v[1] == 14) chk("B_vrender_even", 1, int'(vr_w[1]), 0);
    if (m_field[1] == 1 && m_v[1] == 15) chk("B_vrender_odd", 1, int'(vr_w[1]), 0);
    if (m_hlat[1] == 7 && m_v[1] == 5 && m_h[1] == 3)  chk("B_hs_wrap_hi", 1, int'(hs_w[1]), 1);
    if (m_hlat[1] == 7 && m_v[1] == 5 && m_h[1] == 5)  chk("B_hs_wrap_fall", 1, int'(hs_w[1]), 0);
    if (m_hlat[1] == 7 && m_v[1] == 5 && m_h[1] == 45) chk("B_hs_wrap_rise", 1, int'(hs_w[1]), 1);
  endtask

  task automatic check_reset_literals();
    for (int k = 0; k < 2; k++) begin
      chk("rst_hpos", k, int'(hpos_w[k]), 0);
      chk("rst_vpos", k, int'(vpos_w[k]), 0);
      chk("rst_vrender", k, int'(vr_w[k]), 1);
      chk("rst_lhbl", k, int'(lhbl_w[k]), 1);
      chk("rst_lvbl", k, int'(lvbl_w[k]), 1);
      chk("rst_hs", k, int'(hs_w[k]), 0);
      chk("rst_vs", k, int'(vs_w[k]), 0);
      chk("rst_frame_start", k, int'(fs_w[k]), 0);
      chk("rst_field", k, int'(fld_w[k]), 0);
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    compare_inst(0);
    compare_inst(1);
    literal_checks();
    rst = nx_rst;
    pxl_cen = nx_cen;
    hshift = nx_h;
    vshift = nx_v;
    @(posedge clk);
    model_step(0);
    model_step(1);
  endtask

  task automatic rand_shift(input int one_in);
    if ($urandom_range(0, one_in - 1) == 0) begin
      nx_h = 4'($urandom_range(0, 15));
      nx_v = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1; pxl_cen = 1'b0; hshift = '0; vshift = '0;
    nx_rst = 1'b1; nx_cen = 1'b1; nx_h = '0; nx_v = '0;
    model_reset(0);
    model_reset(1);
    #1;
    check_reset_literals();
    repeat (3) run_cycle();

    nx_rst = 1'b0;
    nx_cen = 1'b1;
    run_cycle();
    #1;
    chk("first_cen_hpos", 0, int'(hpos_w[0]), 1);

    // Slow pixel clock: one enable every 8 clocks.
    for (int i = 0; i < 1600; i++) begin
      nx_cen = ((i % 8) == 0);
      run_cycle();
    end
    // Random enables with occasional mid-field shift changes.
    for (int i = 0; i < 9000; i++) begin
      nx_cen = ($urandom_range(0, 3) != 0);
      rand_shift(150);
      run_cycle();
    end
    // hshift=-3, vshift=+2 then hshift=+7 (wrapping hs fall on instance 1).
    nx_h = 4'd13; nx_v = 4'd2;
    for (int i = 0; i < 3000; i++) begin
      nx_cen = ($urandom_range(0, 4) != 0);
      run_cycle();
    end
    nx_h = 4'd7;
    for (int i = 0; i < 4000; i++) begin
      nx_cen = ($urandom_range(0, 4) != 0);
      run_cycle();
    end

    // Reset mid-frame, between clock edges.
    guard = 0;
    while (!(m_v[0] == 10 && m_h[0] == 20) && guard < 5000) begin
      nx_cen = ($urandom_range(0, 3) != 0);
      run_cycle();
      guard++;
    end
    if (guard >= 5000) begin
      n_vec++;
      n_mis++;
      $display("FAIL reset_point_wait got timeout expected position 10/20");
    end
    #2;
    rst = 1'b1;
    nx_rst = 1'b1;
    #1;
    check_reset_literals();
    model_reset(0);
    model_reset(1);
    nx_cen = 1'b1;
    repeat (2) run_cycle();
    nx_rst = 1'b0;
    run_cycle();
    #1;
    chk("rel_hpos", 0, int'(hpos_w[0]), 1);
    chk("rel_hpos", 1, int'(hpos_w[1]), 1);

    for (int i = 0; i < 3000; i++) begin
      nx_cen = ($urandom_range(0, 3) != 0);
      rand_shift(100);
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
